g7_pattern_ctrl: RTL and testbench
==================================

Name: g7_pattern_ctrl

Overview:
User-input conditioning and pattern-selection stage that sits directly upstream of the LVDS pattern generator in G7_TOP. It synchronises and debounces iSW0..3 and iBUTTON_0..2, then runs a mode FSM (manual step, auto-cycle, switch-direct). It produces the registered pattern index and a change strobe consumed by the timing/pattern generator.

Parameters:
NUM_PAT, 16, number of patterns; legal index 0..NUM_PAT-1; range 2..32.
DEBOUNCE_CYC, 250000, consecutive stable cycles before a debounced level is accepted (10 ms at 25 MHz).
AUTO_PERIOD_CYC, 25000000, cycles between auto-cycle steps (1 s at 25 MHz).
PAT_W, 5, index width; must satisfy 2**PAT_W >= NUM_PAT.

Ports:
iOSC  in  1  system clock, 25 MHz; the only clock.
iRESET  in  1  asynchronous active-low reset.
iSW0..iSW3  in  1 each  raw slide switches; iSW3=1 selects direct mode, iSW2..iSW0 give the direct index.
iBUTTON_0  in  1  raw, active-high: next pattern.
iBUTTON_1  in  1  raw, active-high: previous pattern.
iBUTTON_2  in  1  raw, active-high: toggle auto-cycle.
oPAT_IDX  out  PAT_W  current pattern index, registered.
oPAT_CHG  out  1  one-cycle pulse in the cycle oPAT_IDX takes a new value.
oAUTO  out  1  high while in AUTO state.
oDIRECT  out  1  high while in DIRECT state.

Behaviour:
- Reset (iRESET=0, asynchronous): oPAT_IDX=0, oPAT_CHG=0, oAUTO=0, oDIRECT=0, FSM=MANUAL, all sync/debounce flops=0, timers=0.
- Each input passes through a 2-FF synchroniser, then a debouncer. The counter runs while the synchronised sample differs from the debounced level and clears when it matches. The debounced level flips in the cycle the count reaches DEBOUNCE_CYC-1.
- Press pulse = debounced rising edge, registered. Raw button edge to oPAT_IDX update = DEBOUNCE_CYC+3 cycles.
- FSM states and transitions:
  - MANUAL -> AUTO on the BUTTON_2 pulse.
  - AUTO -> MANUAL on the BUTTON_2 pulse.
  - any state -> DIRECT when debounced SW3=1.
  - DIRECT -> MANUAL when SW3=0; oPAT_IDX keeps its last value.
- MANUAL: a next pulse gives idx+1 and wraps NUM_PAT-1 -> 0. A prev pulse gives idx-1 and wraps 0 -> NUM_PAT-1.
- AUTO: the timer counts 0..AUTO_PERIOD_CYC-1. At terminal count, step next and reload 0. Next/prev pulses also step and clear the timer. The timer clears on entry to AUTO.
- DIRECT:
  - oPAT_IDX = zero-extended debounced {SW2,SW1,SW0}, saturated to NUM_PAT-1.
  - Buttons are ignored; a BUTTON_2 pulse is discarded, not queued.
- Simultaneous next and prev pulses in the same cycle: no step, no oPAT_CHG.
- A terminal count coinciding with a prev pulse: prev wins, single step.
- A BUTTON_2 pulse in the same cycle as a next pulse: the mode toggles and the step is also applied.
- oPAT_CHG asserts only when the new index differs from the old one. A direct-mode rewrite of the same value gives no pulse.
- The outputs never glitch: all are flop outputs.

Optional Feature:
PAT_AUTOREPEAT_EN: when defined, holding next or prev debounced-high for REPEAT_DELAY_CYC (localparam, default DEBOUNCE_CYC*50) generates additional steps every REPEAT_RATE_CYC (default DEBOUNCE_CYC*10) until release; this applies in MANUAL and AUTO only. When undefined, exactly one step per press and the repeat counters are not built.

Decomposition:
- Shared package g7_pkg holds:
  - the pat_mode_t enum {MANUAL, AUTO, DIRECT};
  - the PAT_W default;
  - the 25 MHz clock-frequency constant, used to derive cycle defaults.
- One sub-module, g7_debounce (synchroniser plus debounce counter, parameter DEBOUNCE_CYC, ports iOSC/iRESET/iIN/oLEVEL/oRISE), instantiated 7 times.

Test Plan:
Each scenario uses DEBOUNCE_CYC=4, AUTO_PERIOD_CYC=20, NUM_PAT=16.
- Reset release, press BUTTON_0 for 10 cycles -> oPAT_IDX 0->1 exactly 7 cycles after the raw edge, oPAT_CHG high for 1 cycle.
- BUTTON_0 bounce at 1-cycle toggles for 12 cycles, then stable high -> exactly one step; the index at 15 plus one more press -> wraps to 0. Prev at 0 -> 15.
- BUTTON_2 press -> oAUTO=1; the index advances every 20 cycles (3->4->5). A second press -> oAUTO=0 and the index is frozen.
- SW3=1, SW2..0=3'b101 -> oDIRECT=1, oPAT_IDX=5; with NUM_PAT=4 the index is 3 (saturated); button presses are ignored.
- BUTTON_0 and BUTTON_1 released into debounce on the same cycle -> no index change, no oPAT_CHG.
- iRESET low mid-AUTO (index 9, timer 12) -> outputs are 0 immediately, without a clock edge; after release, MANUAL at index 0.

Source files
------------

// File: rtl/g7_pattern_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// g7_pkg : shared types and constants for the G7 pattern-select front end.
//   pat_mode_t          : mode FSM encoding (MANUAL / AUTO / DIRECT)
//   PAT_W_DEF           : default pattern-index width
//   CLK_HZ              : iOSC frequency, used to derive cycle-count defaults
//   DEBOUNCE_CYC_DEF    : 10 ms of stable input at CLK_HZ
//   AUTO_PERIOD_CYC_DEF : 1 s between auto-cycle steps at CLK_HZ
// ---------------------------------------------------------------------------
package g7_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        DIRECT = 2'd2
    } pat_mode_t;

    localparam int PAT_W_DEF           = 32'd5;
    localparam int CLK_HZ              = 32'd25_000_000;
    localparam int DEBOUNCE_CYC_DEF    = CLK_HZ / 32'd100;
    localparam int AUTO_PERIOD_CYC_DEF = CLK_HZ;

endpackage

// File: rtl/g7_pattern_ctrl_if.sv
// ---------------------------------------------------------------------------
// g7_pattern_ctrl_if : user-input / pattern-select bundle.
//   iSW0..iSW3, iBUTTON_0..2 : raw user inputs (driven by the board side)
//   oPAT_IDX, oPAT_CHG       : registered pattern index and change strobe
//   oAUTO, oDIRECT           : current-mode flags
// Modports: master = board / consumer side, slave = g7_pattern_ctrl.
// ---------------------------------------------------------------------------
interface g7_pattern_ctrl_if
    import g7_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
);
    logic             iSW0;
    logic             iSW1;
    logic             iSW2;
    logic             iSW3;
    logic             iBUTTON_0;
    logic             iBUTTON_1;
    logic             iBUTTON_2;
    logic [PAT_W-1:0] oPAT_IDX;
    logic             oPAT_CHG;
    logic             oAUTO;
    logic             oDIRECT;

    modport master (
        output iSW0, iSW1, iSW2, iSW3, iBUTTON_0, iBUTTON_1, iBUTTON_2,
        input  oPAT_IDX, oPAT_CHG, oAUTO, oDIRECT
    );

    modport slave (
        input  iSW0, iSW1, iSW2, iSW3, iBUTTON_0, iBUTTON_1, iBUTTON_2,
        output oPAT_IDX, oPAT_CHG, oAUTO, oDIRECT
    );
endinterface

// File: rtl/g7_pattern_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// g7_debounce : 2-FF synchroniser followed by a stability counter.
//   iOSC   : clock
//   iRESET : asynchronous active-low reset
//   iIN    : raw asynchronous input
//   oLEVEL : debounced level (flips once the synchronised sample has
//            disagreed with it for DEBOUNCE_CYC-1 consecutive counts)
//   oRISE  : one-cycle registered pulse after oLEVEL rises
// Raw edge -> oLEVEL is DEBOUNCE_CYC+1 cycles; -> oRISE is DEBOUNCE_CYC+2.
// DEBOUNCE_CYC must be >= 2.
// ---------------------------------------------------------------------------
module g7_debounce
    import g7_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic iOSC,
    input  logic iRESET,
    input  logic iIN,
    output logic oLEVEL,
    output logic oRISE
);
    localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    // Counter value in which the next increment would reach DEBOUNCE_CYC-1.
    localparam logic [CW-1:0] CNT_FLIP = CW'(DEBOUNCE_CYC - 2);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          level_d_r;
    logic          rise_r;

    // Synchroniser, stability counter and registered rising-edge detect.
    always_ff @(posedge iOSC or negedge iRESET) begin
        if (!iRESET) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            cnt_r     <= '0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            rise_r    <= 1'b0;
        end else begin
            sync1_r <= iIN;
            sync2_r <= sync1_r;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_FLIP) begin
                cnt_r   <= '0;
                level_r <= sync2_r;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
            level_d_r <= level_r;
            rise_r    <= level_r & ~level_d_r;
        end
    end

    assign oLEVEL = level_r;
    assign oRISE  = rise_r;
endmodule

// File: rtl/g7_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// g7_pattern_ctrl : debounces the slide switches and buttons and runs the
// pattern-select mode FSM (MANUAL step / AUTO cycle / DIRECT switch index).
//   iOSC   : 25 MHz clock
//   iRESET : asynchronous active-low reset
//   bus    : g7_pattern_ctrl_if.slave (raw inputs in, registered outputs)
// Optional build macro PAT_AUTOREPEAT_EN: holding next/prev generates
// repeated steps in MANUAL and AUTO.
// ---------------------------------------------------------------------------
module g7_pattern_ctrl
    import g7_pkg::*;
#(
    parameter int NUM_PAT         = 16,
    parameter int DEBOUNCE_CYC    = DEBOUNCE_CYC_DEF,
    parameter int AUTO_PERIOD_CYC = AUTO_PERIOD_CYC_DEF,
    parameter int PAT_W           = PAT_W_DEF
) (
    input  logic              iOSC,
    input  logic              iRESET,
    g7_pattern_ctrl_if.slave  bus
);
    localparam int TW = (AUTO_PERIOD_CYC > 2) ? $clog2(AUTO_PERIOD_CYC) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(AUTO_PERIOD_CYC - 1);
    localparam logic [PAT_W-1:0] IDX_LAST   = PAT_W'(NUM_PAT - 1);

    // Switch-direct index, zero-extended and clamped to the last pattern.
    function automatic logic [PAT_W-1:0] sat_idx(input logic [2:0] sw);
        if (int'(sw) > NUM_PAT - 1) begin
            sat_idx = IDX_LAST;
        end else begin
            sat_idx = PAT_W'(sw);
        end
    endfunction

    // Bit map: 0 next, 1 prev, 2 auto toggle, 3..5 SW0..SW2, 6 SW3.
    logic [6:0]       raw_s;
    logic [6:0]       level_s;
    logic [6:0]       rise_s;
    logic             rpt_up_s;
    logic             rpt_dn_s;
    logic             up_s;
    logic             dn_s;
    logic             tc_s;
    logic             step_up_s;
    logic             step_dn_s;
    logic [PAT_W-1:0] idx_nxt_s;
    logic             unused_s;

    pat_mode_t        mode_r;
    logic [TW-1:0]    timer_r;
    logic [PAT_W-1:0] idx_r;
    logic             chg_r;
    logic             auto_r;
    logic             direct_r;

    assign raw_s = {bus.iSW3, bus.iSW2, bus.iSW1, bus.iSW0,
                    bus.iBUTTON_2, bus.iBUTTON_1, bus.iBUTTON_0};

    for (genvar g = 0; g < 7; g++) begin : g_in
        g7_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .iOSC   (iOSC),
            .iRESET (iRESET),
            .iIN    (raw_s[g]),
            .oLEVEL (level_s[g]),
            .oRISE  (rise_s[g])
        );
    end

`ifdef PAT_AUTOREPEAT_EN
    localparam int REPEAT_DELAY_CYC = DEBOUNCE_CYC * 50;
    localparam int REPEAT_RATE_CYC  = DEBOUNCE_CYC * 10;
    localparam int RW = $clog2(REPEAT_DELAY_CYC);

    logic [RW-1:0] rpt_cnt_r;
    logic          rpt_armed_r;
    logic          rpt_up_r;
    logic          rpt_dn_r;
    logic          held_s;

    // Exactly one of next/prev held, outside direct mode.
    assign held_s = (level_s[0] ^ level_s[1]) && (mode_r != DIRECT) && !level_s[6];

    // Hold timer: first repeat after the delay, then one per rate period.
    always_ff @(posedge iOSC or negedge iRESET) begin
        if (!iRESET) begin
            rpt_cnt_r   <= '0;
            rpt_armed_r <= 1'b0;
            rpt_up_r    <= 1'b0;
            rpt_dn_r    <= 1'b0;
        end else begin
            rpt_up_r <= 1'b0;
            rpt_dn_r <= 1'b0;
            if (!held_s) begin
                rpt_cnt_r   <= '0;
                rpt_armed_r <= 1'b0;
            end else if ((!rpt_armed_r && rpt_cnt_r == RW'(REPEAT_DELAY_CYC - 1)) ||
                         (rpt_armed_r && rpt_cnt_r == RW'(REPEAT_RATE_CYC - 1))) begin
                rpt_cnt_r   <= '0;
                rpt_armed_r <= 1'b1;
                rpt_up_r    <= level_s[0];
                rpt_dn_r    <= level_s[1];
            end else begin
                rpt_cnt_r <= rpt_cnt_r + 1'b1;
            end
        end
    end

    assign rpt_up_s = rpt_up_r;
    assign rpt_dn_s = rpt_dn_r;
`else
    assign rpt_up_s = 1'b0;
    assign rpt_dn_s = 1'b0;
`endif

    assign unused_s = &{1'b0, rise_s[6:3], level_s[2:0]};

    // Step decision and next index; prev beats a coincident terminal count.
    always_comb begin
        up_s      = rise_s[0] | rpt_up_s;
        dn_s      = rise_s[1] | rpt_dn_s;
        tc_s      = (timer_r == TIMER_LAST);
        step_up_s = 1'b0;
        step_dn_s = 1'b0;
        idx_nxt_s = idx_r;
        if (level_s[6] || mode_r == DIRECT) begin
            step_up_s = 1'b0;
            step_dn_s = 1'b0;
        end else if (up_s && !dn_s) begin
            step_up_s = 1'b1;
        end else if (dn_s && !up_s) begin
            step_dn_s = 1'b1;
        end else if (!up_s && !dn_s && mode_r == AUTO && tc_s) begin
            step_up_s = 1'b1;
        end else begin
            step_up_s = 1'b0;
            step_dn_s = 1'b0;
        end

        if (level_s[6]) begin
            idx_nxt_s = sat_idx({level_s[5], level_s[4], level_s[3]});
        end else if (step_up_s) begin
            idx_nxt_s = (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
        end else if (step_dn_s) begin
            idx_nxt_s = (idx_r == '0) ? IDX_LAST : idx_r - 1'b1;
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Mode FSM, auto-cycle timer and registered outputs.
    always_ff @(posedge iOSC or negedge iRESET) begin
        if (!iRESET) begin
            mode_r   <= MANUAL;
            timer_r  <= '0;
            idx_r    <= '0;
            chg_r    <= 1'b0;
            auto_r   <= 1'b0;
            direct_r <= 1'b0;
        end else begin
            idx_r <= idx_nxt_s;
            chg_r <= (idx_nxt_s != idx_r);
            if (level_s[6]) begin
                mode_r   <= DIRECT;
                timer_r  <= '0;
                auto_r   <= 1'b0;
                direct_r <= 1'b1;
            end else begin
                case (mode_r)
                    MANUAL: begin
                        timer_r  <= '0;
                        direct_r <= 1'b0;
                        if (rise_s[2]) begin
                            mode_r <= AUTO;
                            auto_r <= 1'b1;
                        end else begin
                            mode_r <= MANUAL;
                            auto_r <= 1'b0;
                        end
                    end
                    AUTO: begin
                        direct_r <= 1'b0;
                        if (up_s || dn_s || tc_s) begin
                            timer_r <= '0;
                        end else begin
                            timer_r <= timer_r + 1'b1;
                        end
                        if (rise_s[2]) begin
                            mode_r <= MANUAL;
                            auto_r <= 1'b0;
                        end else begin
                            mode_r <= AUTO;
                            auto_r <= 1'b1;
                        end
                    end
                    DIRECT: begin
                        // Leaving direct mode keeps the last index.
                        mode_r   <= MANUAL;
                        timer_r  <= '0;
                        auto_r   <= 1'b0;
                        direct_r <= 1'b0;
                    end
                    default: begin
                        mode_r   <= MANUAL;
                        timer_r  <= '0;
                        auto_r   <= 1'b0;
                        direct_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.oPAT_IDX = idx_r;
    assign bus.oPAT_CHG = chg_r;
    assign bus.oAUTO    = auto_r;
    assign bus.oDIRECT  = direct_r;
endmodule

// File: tb/tb_g7_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for g7_pattern_ctrl with DEBOUNCE_CYC=4, AUTO_PERIOD_CYC=20.
// dut_a: NUM_PAT=16 (main scenarios); dut_b: NUM_PAT=4 (direct saturation).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_g7_pattern_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors    = 0;
    int   checks    = 0;
    int   chg_cnt_a = 0;
    int   chg_cnt_b = 0;

    always #5 clk = ~clk;

    g7_pattern_ctrl_if #(.PAT_W(5)) bus_a ();
    g7_pattern_ctrl_if #(.PAT_W(5)) bus_b ();

    g7_pattern_ctrl #(.NUM_PAT(16), .DEBOUNCE_CYC(4), .AUTO_PERIOD_CYC(20), .PAT_W(5)) dut_a (
        .iOSC(clk), .iRESET(rst_n), .bus(bus_a)
    );
    g7_pattern_ctrl #(.NUM_PAT(4), .DEBOUNCE_CYC(4), .AUTO_PERIOD_CYC(20), .PAT_W(5)) dut_b (
        .iOSC(clk), .iRESET(rst_n), .bus(bus_b)
    );

    // Count change strobes seen by each instance.
    always @(negedge clk) begin
        if (bus_a.oPAT_CHG === 1'b1) chg_cnt_a++;
        if (bus_b.oPAT_CHG === 1'b1) chg_cnt_b++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn_a(input logic [2:0] m);
        bus_a.iBUTTON_0 = m[0];
        bus_a.iBUTTON_1 = m[1];
        bus_a.iBUTTON_2 = m[2];
    endtask

    task automatic set_sw(input logic [3:0] s);
        {bus_a.iSW3, bus_a.iSW2, bus_a.iSW1, bus_a.iSW0} = s;
        {bus_b.iSW3, bus_b.iSW2, bus_b.iSW1, bus_b.iSW0} = s;
    endtask

    task automatic press_a(input logic [2:0] m, input int hold);
        set_btn_a(m);
        tick(hold);
        set_btn_a(3'b000);
        tick(12);
    endtask

    task automatic test_reset();
        set_btn_a(3'b000);
        bus_b.iBUTTON_0 = 1'b0; bus_b.iBUTTON_1 = 1'b0; bus_b.iBUTTON_2 = 1'b0;
        set_sw(4'b0000);
        #12;
        checks++; if (bus_a.oPAT_IDX !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", bus_a.oPAT_IDX); end
        checks++; if (bus_a.oPAT_CHG !== 1'b0) begin errors++; $display("FAIL reset_chg: got %b expected 0", bus_a.oPAT_CHG); end
        checks++; if (bus_a.oAUTO !== 1'b0) begin errors++; $display("FAIL reset_auto: got %b expected 0", bus_a.oAUTO); end
        checks++; if (bus_a.oDIRECT !== 1'b0) begin errors++; $display("FAIL reset_direct: got %b expected 0", bus_a.oDIRECT); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_single_step();
        logic [4:0] exp_idx;
        logic       exp_chg;
        set_btn_a(3'b001);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp_idx = (k >= 7) ? 5'd1 : 5'd0;
            exp_chg = (k == 7);
            checks++; if (bus_a.oPAT_IDX !== exp_idx) begin errors++; $display("FAIL step_idx@%0d: got %0d expected %0d", k, bus_a.oPAT_IDX, exp_idx); end
            checks++; if (bus_a.oPAT_CHG !== exp_chg) begin errors++; $display("FAIL step_chg@%0d: got %b expected %b", k, bus_a.oPAT_CHG, exp_chg); end
        end
        tick(2);
        set_btn_a(3'b000);
        tick(12);
    endtask

    task automatic test_bounce_wrap();
        int start;
        start = chg_cnt_a;
        for (int i = 0; i < 12; i++) begin
            bus_a.iBUTTON_0 = (i % 2 == 0);
            tick(1);
        end
        press_a(3'b001, 10);
        checks++; if (bus_a.oPAT_IDX !== 5'd2) begin errors++; $display("FAIL bounce_idx: got %0d expected 2", bus_a.oPAT_IDX); end
        checks++; if (chg_cnt_a - start !== 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected 1", chg_cnt_a - start); end
        for (int i = 0; i < 13; i++) press_a(3'b001, 10);
        checks++; if (bus_a.oPAT_IDX !== 5'd15) begin errors++; $display("FAIL reach_15: got %0d expected 15", bus_a.oPAT_IDX); end
        start = chg_cnt_a;
        press_a(3'b001, 10);
        checks++; if (bus_a.oPAT_IDX !== 5'd0) begin errors++; $display("FAIL wrap_up: got %0d expected 0", bus_a.oPAT_IDX); end
        checks++; if (chg_cnt_a - start !== 1) begin errors++; $display("FAIL wrap_up_pulse: got %0d expected 1", chg_cnt_a - start); end
        press_a(3'b010, 10);
        checks++; if (bus_a.oPAT_IDX !== 5'd15) begin errors++; $display("FAIL wrap_down: got %0d expected 15", bus_a.oPAT_IDX); end
    endtask

    task automatic test_auto();
        for (int i = 0; i < 4; i++) press_a(3'b001, 10);
        checks++; if (bus_a.oPAT_IDX !== 5'd3) begin errors++; $display("FAIL auto_pre_idx: got %0d expected 3", bus_a.oPAT_IDX); end
        set_btn_a(3'b100);
        tick(7);
        checks++; if (bus_a.oAUTO !== 1'b1) begin errors++; $display("FAIL auto_enter: got %b expected 1", bus_a.oAUTO); end
        tick(3);
        set_btn_a(3'b000);
        tick(16);
        checks++; if (bus_a.oPAT_IDX !== 5'd3) begin errors++; $display("FAIL auto_hold: got %0d expected 3", bus_a.oPAT_IDX); end
        tick(1);
        checks++; if (bus_a.oPAT_IDX !== 5'd4) begin errors++; $display("FAIL auto_step1: got %0d expected 4", bus_a.oPAT_IDX); end
        checks++; if (bus_a.oPAT_CHG !== 1'b1) begin errors++; $display("FAIL auto_step1_chg: got %b expected 1", bus_a.oPAT_CHG); end
        tick(20);
        checks++; if (bus_a.oPAT_IDX !== 5'd5) begin errors++; $display("FAIL auto_step2: got %0d expected 5", bus_a.oPAT_IDX); end
        set_btn_a(3'b100);
        tick(7);
        checks++; if (bus_a.oAUTO !== 1'b0) begin errors++; $display("FAIL auto_exit: got %b expected 0", bus_a.oAUTO); end
        tick(3);
        set_btn_a(3'b000);
        tick(40);
        checks++; if (bus_a.oPAT_IDX !== 5'd5) begin errors++; $display("FAIL auto_frozen: got %0d expected 5", bus_a.oPAT_IDX); end
    endtask

    task automatic test_direct();
        int start_a;
        int start_b;
        start_a = chg_cnt_a;
        start_b = chg_cnt_b;
        set_sw(4'b1101);
        tick(5);
        checks++; if (bus_a.oDIRECT !== 1'b0) begin errors++; $display("FAIL direct_early: got %b expected 0", bus_a.oDIRECT); end
        tick(1);
        checks++; if (bus_a.oDIRECT !== 1'b1) begin errors++; $display("FAIL direct_enter: got %b expected 1", bus_a.oDIRECT); end
        checks++; if (bus_a.oPAT_IDX !== 5'd5) begin errors++; $display("FAIL direct_idx: got %0d expected 5", bus_a.oPAT_IDX); end
        checks++; if (bus_b.oPAT_IDX !== 5'd3) begin errors++; $display("FAIL direct_sat: got %0d expected 3", bus_b.oPAT_IDX); end
        checks++; if (bus_b.oPAT_CHG !== 1'b1) begin errors++; $display("FAIL direct_sat_chg: got %b expected 1", bus_b.oPAT_CHG); end
        press_a(3'b001, 10);
        press_a(3'b100, 10);
        checks++; if (bus_a.oPAT_IDX !== 5'd5) begin errors++; $display("FAIL direct_btn_idx: got %0d expected 5", bus_a.oPAT_IDX); end
        checks++; if (bus_a.oAUTO !== 1'b0) begin errors++; $display("FAIL direct_btn_auto: got %b expected 0", bus_a.oAUTO); end
        checks++; if (chg_cnt_a - start_a !== 0) begin errors++; $display("FAIL direct_same_pulse: got %0d expected 0", chg_cnt_a - start_a); end
        checks++; if (chg_cnt_b - start_b !== 1) begin errors++; $display("FAIL direct_b_pulses: got %0d expected 1", chg_cnt_b - start_b); end
        set_sw(4'b1010);
        tick(6);
        checks++; if (bus_a.oPAT_IDX !== 5'd2) begin errors++; $display("FAIL direct_rewrite: got %0d expected 2", bus_a.oPAT_IDX); end
        checks++; if (bus_a.oPAT_CHG !== 1'b1) begin errors++; $display("FAIL direct_rewrite_chg: got %b expected 1", bus_a.oPAT_CHG); end
        checks++; if (bus_b.oPAT_IDX !== 5'd2) begin errors++; $display("FAIL direct_b_rewrite: got %0d expected 2", bus_b.oPAT_IDX); end
        set_sw(4'b0010);
        tick(6);
        checks++; if (bus_a.oDIRECT !== 1'b0) begin errors++; $display("FAIL direct_exit: got %b expected 0", bus_a.oDIRECT); end
        tick(10);
        checks++; if (bus_a.oPAT_IDX !== 5'd2) begin errors++; $display("FAIL direct_keep_idx: got %0d expected 2", bus_a.oPAT_IDX); end
        checks++; if (bus_a.oAUTO !== 1'b0) begin errors++; $display("FAIL direct_no_queue: got %b expected 0", bus_a.oAUTO); end
    endtask

    task automatic test_simultaneous();
        int start;
        start = chg_cnt_a;
        press_a(3'b011, 10);
        checks++; if (bus_a.oPAT_IDX !== 5'd2) begin errors++; $display("FAIL simul_idx: got %0d expected 2", bus_a.oPAT_IDX); end
        checks++; if (chg_cnt_a - start !== 0) begin errors++; $display("FAIL simul_pulse: got %0d expected 0", chg_cnt_a - start); end
    endtask

    task automatic test_toggle_step_reset();
        set_btn_a(3'b101);
        tick(7);
        checks++; if (bus_a.oPAT_IDX !== 5'd3) begin errors++; $display("FAIL toggle_step_idx: got %0d expected 3", bus_a.oPAT_IDX); end
        checks++; if (bus_a.oAUTO !== 1'b1) begin errors++; $display("FAIL toggle_step_auto: got %b expected 1", bus_a.oAUTO); end
        tick(3);
        set_btn_a(3'b000);
        tick(129);
        checks++; if (bus_a.oPAT_IDX !== 5'd9) begin errors++; $display("FAIL pre_reset_idx: got %0d expected 9", bus_a.oPAT_IDX); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.oPAT_IDX !== 5'd0) begin errors++; $display("FAIL async_idx: got %0d expected 0", bus_a.oPAT_IDX); end
        checks++; if (bus_a.oAUTO !== 1'b0) begin errors++; $display("FAIL async_auto: got %b expected 0", bus_a.oAUTO); end
        checks++; if (bus_a.oPAT_CHG !== 1'b0) begin errors++; $display("FAIL async_chg: got %b expected 0", bus_a.oPAT_CHG); end
        checks++; if (bus_a.oDIRECT !== 1'b0) begin errors++; $display("FAIL async_direct: got %b expected 0", bus_a.oDIRECT); end
        tick(2);
        rst_n = 1'b1;
        tick(30);
        checks++; if (bus_a.oPAT_IDX !== 5'd0) begin errors++; $display("FAIL post_reset_idx: got %0d expected 0", bus_a.oPAT_IDX); end
        checks++; if (bus_a.oAUTO !== 1'b0) begin errors++; $display("FAIL post_reset_auto: got %b expected 0", bus_a.oAUTO); end
        press_a(3'b001, 10);
        checks++; if (bus_a.oPAT_IDX !== 5'd1) begin errors++; $display("FAIL post_reset_step: got %0d expected 1", bus_a.oPAT_IDX); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_bounce_wrap();
        test_auto();
        test_direct();
        test_simultaneous();
        test_toggle_step_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
